// File: rtl/torrent_word_receiver.sv
// Serial word receiver for the Torrent loop-back path. It deserialises framed
// words (start, data MSB first, even parity, stop), then counts words and errors.
module torrent_word_receiver #(
  parameter int WORD_W = 18,
  parameter int CNT_W  = 16,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bit_en,
  input  logic              serial_in,
  input  logic              enable,
  input  logic              clear,
  input  logic [CNT_W-1:0]  num_words,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              block_done,
  output logic [CNT_W-1:0]  word_count,
  output logic [ERR_W-1:0]  err_count,
  output logic              busy
);

  localparam int IDX_W = $clog2(WORD_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic               par_q, par_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               valid_q, valid_d;
  logic               perr_q, perr_d;
  logic               ferr_q, ferr_d;
  logic               bd_q, bd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic               par_ok;
  logic [CNT_W-1:0]   cnt_inc;
  logic [ERR_W-1:0]   err_inc;

  assign par_ok  = ~((^shreg_q) ^ par_q);
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign err_inc = (err_q == '1) ? err_q : err_q + ERR_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    word_d  = word_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    bd_d    = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bit_en && !serial_in) begin
          state_d = S_DATA;
          idx_d   = IDX_W'(WORD_W - 1);
        end
      end
      S_DATA: begin
        if (bit_en) begin
          shreg_d = {shreg_q[WORD_W-2:0], serial_in};
          if (idx_q == '0) state_d = S_PARITY;
          else             idx_d   = idx_q - IDX_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_en) begin
          par_d   = serial_in;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_en) begin
          if (!serial_in) begin
            // A bad stop bit masks any parity error on the same frame.
            ferr_d  = 1'b1;
            err_d   = err_inc;
            state_d = S_BREAK;
          end else if (!par_ok) begin
            perr_d  = 1'b1;
            err_d   = err_inc;
            state_d = S_IDLE;
          end else begin
            word_d  = shreg_q;
            valid_d = 1'b1;
            if ((num_words != '0) && (cnt_inc == num_words)) begin
              bd_d  = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_inc;
            end
            state_d = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        if (bit_en && serial_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!enable) begin
      state_d = S_IDLE;
      word_d  = word_q;
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      bd_d    = 1'b0;
      cnt_d   = cnt_q;
      err_d   = err_q;
    end

    // clear wins over everything, including a word completing this cycle.
    if (clear) begin
      state_d = S_IDLE;
      word_d  = word_q;
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      bd_d    = 1'b0;
      cnt_d   = '0;
      err_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      bd_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      bd_q    <= bd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign block_done = bd_q;
  assign word_count = cnt_q;
  assign err_count  = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_torrent_word_receiver.sv
// Directed bench for torrent_word_receiver: the frame driver tells a
// transaction-level model what each frame should produce; outputs compared every cycle.
module tb_torrent_word_receiver;

  localparam int WORD_W = 18;
  localparam int CNT_W  = 16;
  localparam int ERR_W  = 8;

  localparam int K_NONE = 0;
  localparam int K_ACC  = 1;
  localparam int K_PERR = 2;
  localparam int K_FERR = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              bit_en = 1'b0;
  logic              serial_in = 1'b1;
  logic              enable = 1'b1;
  logic              clear = 1'b0;
  logic [CNT_W-1:0]  num_words = '0;
  logic [WORD_W-1:0] word_out;
  logic              word_valid, parity_err, frame_err, block_done, busy;
  logic [CNT_W-1:0]  word_count;
  logic [ERR_W-1:0]  err_count;

  always #5 clk = ~clk;

  torrent_word_receiver #(
    .WORD_W(WORD_W),
    .CNT_W (CNT_W),
    .ERR_W (ERR_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bit_en    (bit_en),
    .serial_in (serial_in),
    .enable    (enable),
    .clear     (clear),
    .num_words (num_words),
    .word_out  (word_out),
    .word_valid(word_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .block_done(block_done),
    .word_count(word_count),
    .err_count (err_count),
    .busy      (busy)
  );

  int n_vec = 0;
  int n_bad = 0;
  int pend  = K_NONE;
  int gap   = 0;
  logic [WORD_W-1:0] pend_word = '0;

  // Transaction-level expectation: what the link should show after each edge.
  logic [WORD_W-1:0] m_word;
  logic              m_valid, m_perr, m_ferr, m_bd;
  logic [CNT_W-1:0]  m_cnt, m_cnt_inc;
  logic [ERR_W-1:0]  m_err;
  assign m_cnt_inc = m_cnt + 16'd1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_word <= '0; m_valid <= 1'b0; m_perr <= 1'b0; m_ferr <= 1'b0;
      m_bd <= 1'b0; m_cnt <= '0; m_err <= '0;
    end else begin
      m_valid <= 1'b0; m_perr <= 1'b0; m_ferr <= 1'b0; m_bd <= 1'b0;
      if (clear) begin
        m_cnt <= '0;
        m_err <= '0;
      end else if (enable && pend == K_ACC) begin
        m_word  <= pend_word;
        m_valid <= 1'b1;
        if (num_words != 0 && m_cnt_inc == num_words) begin
          m_bd  <= 1'b1;
          m_cnt <= '0;
        end else begin
          m_cnt <= m_cnt_inc;
        end
      end else if (enable && (pend == K_PERR || pend == K_FERR)) begin
        m_perr <= (pend == K_PERR);
        m_ferr <= (pend == K_FERR);
        if (m_err != 8'hFF) m_err <= m_err + 8'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    #2;
    chk("word_out",   32'(word_out),   32'(m_word));
    chk("word_valid", 32'(word_valid), 32'(m_valid));
    chk("parity_err", 32'(parity_err), 32'(m_perr));
    chk("frame_err",  32'(frame_err),  32'(m_ferr));
    chk("block_done", 32'(block_done), 32'(m_bd));
    chk("word_count", 32'(word_count), 32'(m_cnt));
    chk("err_count",  32'(err_count),  32'(m_err));
  end

  task automatic send_bit(input logic b, input int k);
    serial_in = b;
    bit_en    = 1'b1;
    pend      = k;
    @(negedge clk);
    pend = K_NONE;
    repeat (gap) begin
      bit_en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_partial(input logic [WORD_W-1:0] w, input int nbits);
    send_bit(1'b0, K_NONE);
    for (int i = 0; i < nbits; i++) send_bit(w[WORD_W-1-i], K_NONE);
  endtask

  task automatic send_frame(input logic [WORD_W-1:0] w, input logic bad_par,
                            input logic stop, input logic clr_at_stop);
    int k;
    send_partial(w, WORD_W);
    send_bit((^w) ^ bad_par, K_NONE);
    k = !stop ? K_FERR : (bad_par ? K_PERR : K_ACC);
    pend_word = w;
    clear = clr_at_stop;
    send_bit(stop, k);
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    bit_en    = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst word_out", 32'(word_out), 32'd0);
    chk("rst word_count", 32'(word_count), 32'd0);
    chk("rst err_count", 32'(err_count), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Single word, bit_en tied high.
    send_frame(18'h2A5C3, 1'b0, 1'b1, 1'b0);
    chk("t1 valid", 32'(word_valid), 32'd1);
    chk("t1 word", 32'(word_out), 32'h2A5C3);
    chk("t1 count", 32'(word_count), 32'd1);
    idle(2);
    chk("t1 valid drop", 32'(word_valid), 32'd0);

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr count", 32'(word_count), 32'd0);

    // Block of three, back to back.
    num_words = 16'd3;
    send_frame(18'h00001, 1'b0, 1'b1, 1'b0);
    send_frame(18'h3FFFF, 1'b0, 1'b1, 1'b0);
    send_frame(18'h12345, 1'b0, 1'b1, 1'b0);
    chk("t2 block_done", 32'(block_done), 32'd1);
    chk("t2 count", 32'(word_count), 32'd0);
    chk("t2 word", 32'(word_out), 32'h12345);
    idle(2);

    // Parity error then a good word.
    send_frame(18'h00001, 1'b1, 1'b1, 1'b0);
    chk("t3 perr", 32'(parity_err), 32'd1);
    chk("t3 no valid", 32'(word_valid), 32'd0);
    chk("t3 err_count", 32'(err_count), 32'd1);
    send_frame(18'h2FFFF, 1'b0, 1'b1, 1'b0);
    chk("t3 count", 32'(word_count), 32'd1);

    // Framing error, line held low, recovery.
    send_frame(18'h0ABCD, 1'b0, 1'b0, 1'b0);
    chk("t4 ferr", 32'(frame_err), 32'd1);
    chk("t4 err_count", 32'(err_count), 32'd2);
    repeat (5) send_bit(1'b0, K_NONE);
    chk("t4 break busy", 32'(busy), 32'd1);
    send_bit(1'b1, K_NONE);
    chk("t4 idle busy", 32'(busy), 32'd0);
    send_frame(18'h00F0F, 1'b0, 1'b1, 1'b0);
    chk("t4 word", 32'(word_out), 32'h00F0F);
    chk("t4 count", 32'(word_count), 32'd2);

    // Sparse bit_en, 1 in 4 clocks; completes the block of three.
    gap = 3;
    send_frame(18'h15555, 1'b0, 1'b1, 1'b0);
    gap = 0;
    chk("t5 word", 32'(word_out), 32'h15555);
    chk("t5 count", 32'(word_count), 32'd0);
    idle(1);

    // Reset in the middle of data.
    send_partial(18'h3C3C3, 9);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t6 rst count", 32'(word_count), 32'd0);
    chk("t6 rst word", 32'(word_out), 32'd0);
    chk("t6 rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    send_frame(18'h0AAAA, 1'b0, 1'b1, 1'b0);
    chk("t6 word", 32'(word_out), 32'h0AAAA);
    chk("t6 count", 32'(word_count), 32'd1);

    // clear coinciding with the stop sample.
    send_frame(18'h11111, 1'b0, 1'b1, 1'b1);
    chk("t7 no valid", 32'(word_valid), 32'd0);
    chk("t7 count", 32'(word_count), 32'd0);
    chk("t7 word kept", 32'(word_out), 32'h0AAAA);
    send_frame(18'h22222, 1'b0, 1'b1, 1'b0);
    chk("t7 count after", 32'(word_count), 32'd1);

    // enable dropped mid-frame.
    send_partial(18'h33333, 5);
    enable = 1'b0;
    @(negedge clk);
    chk("t8 busy", 32'(busy), 32'd0);
    enable = 1'b1;
    idle(2);
    send_frame(18'h01234, 1'b0, 1'b1, 1'b0);
    chk("t8 word", 32'(word_out), 32'h01234);
    chk("t8 count", 32'(word_count), 32'd2);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/torrent_word_receiver.md
Name: torrent_word_receiver

Overview:
- Receive side of the serial word link that pixel_processor drives toward the Torrent (data_out_to_torrent / muestras_guardadas_to_torrent).
- Deserialises framed 18-bit words from one serial line and checks parity and framing.
- Presents each accepted word with a one-cycle valid strobe and counts words per block against a programmed block length.
- Used on the loop-back/test path to check processed samples and addresses without external hardware.

Parameters:
- WORD_W, 18, data bits per frame.
- CNT_W, 16, width of the block word counter and num_words.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- bit_en  in  1  bit-time strobe; the line is sampled only in clk cycles where bit_en=1.
- serial_in  in  1  serial line; idles high.
- enable  in  1  when 0, the FSM holds IDLE and ignores the line.
- clear  in  1  synchronous; zeroes word_count and err_count and forces IDLE.
- num_words  in  CNT_W  words per block; 0 means never signal block_done.
- word_out  out  WORD_W  last accepted word.
- word_valid  out  1  one-cycle pulse when word_out updates.
- parity_err  out  1  one-cycle pulse on parity failure.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- block_done  out  1  one-cycle pulse when the block word count is reached.
- word_count  out  CNT_W  accepted words in the current block.
- err_count  out  ERR_W  parity plus framing errors; saturates at all-ones.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Frame format: start bit 0, then WORD_W data bits MSB first, then an even-parity bit (XOR of data bits and parity bit = 0), then stop bit 1. One bit per bit_en; 21 bit_en samples per frame.
- Reset: all outputs 0, FSM in IDLE, shift register 0.
- States:
  - IDLE: if enable && bit_en && serial_in==0, go to DATA with bit index = WORD_W-1.
  - DATA: on each bit_en, shift serial_in in at the LSB. After the sample at index 0, go to PARITY.
  - PARITY: on bit_en, latch the parity bit and go to STOP.
  - STOP: on bit_en:
    - stop=1 and parity ok: accept the word.
    - stop=1 and parity bad: pulse parity_err, discard the word, go to IDLE.
    - stop=0: pulse frame_err, discard the word (even if parity is also bad; only frame_err pulses), go to BREAK.
  - BREAK: on bit_en with serial_in==1, go to IDLE.
- Accept: in the clk cycle after the stop-bit bit_en, word_out is updated, word_valid=1 and word_count increments. Latency is one clk from the stop sample to word_valid.
- Block end: if num_words!=0 and the incremented count equals num_words, pulse block_done in the same cycle as word_valid and load word_count to 0 instead of num_words.
- num_words changed mid-block: the compare uses the current value. If word_count already exceeds it, the count runs to wrap at 2^CNT_W without block_done.
- Error pulses occur in the cycle after the stop sample; err_count increments at the same time and saturates.
- bit_en=0 cycles: FSM and shift register hold. bit_en may be tied high (one bit per clk).
- enable deasserted mid-frame: the frame is abandoned, FSM goes to IDLE next clk, and no pulses are generated.
- clear has priority over accept and error updates in the same cycle: counters become 0, no block_done, FSM goes to IDLE. A word_valid due in that cycle is suppressed.
- reset_n asserted mid-frame: immediate return to the reset state; the partial word is lost.
- Back-to-back frames: a start bit may be sampled on the bit_en immediately after the stop bit. No idle bit is required.

Test Plan:
- bit_en=1, send 18'h2A5C3 with correct parity and stop -> word_out=18'h2A5C3 and word_valid=1 exactly 1 clk after the stop sample; word_count=1.
- num_words=3, three back-to-back frames 0x00001, 0x3FFFF, 0x12345 -> three word_valid pulses with the correct values; block_done coincides with the third; word_count=0 afterwards.
- Frame 0x00001 with the parity bit flipped -> parity_err pulse, no word_valid, err_count=1; the next good frame is accepted normally.
- Frame with stop=0, then line held low 5 bits then high -> frame_err pulse, FSM stays in BREAK until the line goes high, then a following good frame is accepted.
- bit_en pulsing 1-in-4 clks, word 0x15555 -> word received correctly; word_valid is 1 clk after the stop-bit bit_en cycle.
- reset_n low at data bit 9, or clear asserted on the accept cycle -> no word_valid pulse; counters are 0; the next frame is received correctly.
